// File: rtl/temp_logger.sv
// Temperature logger: stores averaged readings into a 2048x8 RAM, serves reads,
// and keeps sample count, min/max, wrap, overrun and over-temperature alarm status.
module temp_logger #(
   parameter logic [7:0]  TEMP_HI   = 8'd200,
   parameter int unsigned ALARM_CNT = 3
) (
   input  logic        wr_clk,
   input  logic        reset,
   input  logic        avg_valid,
   input  logic [7:0]  avg_data,
   input  logic [10:0] avg_addr,
   input  logic        rd_req,
   input  logic [10:0] rd_addr,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic [11:0] sample_count,
   output logic [7:0]  min_temp,
   output logic [7:0]  max_temp,
   output logic        wrap_flag,
   output logic        overrun,
   output logic        alarm,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

   localparam logic [3:0] ALARM_MAX = 4'(ALARM_CNT);

   // Handshake: avg_valid is a one-cycle strobe captured unconditionally;
   // rd_req is a level held until rd_valid pulses for one cycle.

   state_t      state_q, state_d;
   logic        rd_phase_q, rd_phase_d;
   logic        pend_vld_q, pend_vld_d;
   logic [10:0] pend_addr_q, pend_addr_d;
   logic [7:0]  pend_data_q, pend_data_d;
   logic [10:0] rd_addr_q, rd_addr_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic [11:0] sample_count_q, sample_count_d;
   logic [7:0]  min_q, min_d;
   logic [7:0]  max_q, max_d;
   logic        wrap_q, wrap_d;
   logic        overrun_q, overrun_d;
   logic [3:0]  alarm_cnt_q, alarm_cnt_d;
   logic        alarm_q, alarm_d;
   logic        ram_we, ram_re;

   logic [7:0]  mem [0:2047];
   logic [7:0]  ram_rd_q;

   always_comb begin
      state_d        = state_q;
      rd_phase_d     = 1'b0;
      pend_vld_d     = pend_vld_q;
      pend_addr_d    = pend_addr_q;
      pend_data_d    = pend_data_q;
      rd_addr_d      = rd_addr_q;
      rd_data_d      = rd_data_q;
      rd_valid_d     = 1'b0;
      sample_count_d = sample_count_q;
      min_d          = min_q;
      max_d          = max_q;
      wrap_d         = wrap_q;
      overrun_d      = overrun_q;
      alarm_cnt_d    = alarm_cnt_q;
      ram_we         = 1'b0;
      ram_re         = 1'b0;

      case (state_q)
         IDLE: begin
            // A reading arriving this cycle outranks a read request.
            if (pend_vld_q) begin
               state_d = WR;
            end else if (rd_req && !avg_valid) begin
               state_d   = RD;
               rd_addr_d = rd_addr;
            end
         end
         WR: begin
            ram_we     = 1'b1;
            pend_vld_d = 1'b0;
            if (sample_count_q != 12'hFFF) sample_count_d = sample_count_q + 12'd1;
            if (pend_data_q < min_q) min_d = pend_data_q;
            if (pend_data_q > max_q) max_d = pend_data_q;
            if (pend_addr_q == 11'h000) wrap_d = 1'b1;
            if (pend_data_q >= TEMP_HI) begin
               if (alarm_cnt_q != ALARM_MAX) alarm_cnt_d = alarm_cnt_q + 4'd1;
            end else begin
               alarm_cnt_d = 4'd0;
            end
            state_d = IDLE;
         end
         RD: begin
            // Two phases: synchronous RAM read, then register onto rd_data.
            if (!rd_phase_q) begin
               ram_re     = 1'b1;
               rd_phase_d = 1'b1;
            end else begin
               rd_data_d  = ram_rd_q;
               rd_valid_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (avg_valid) begin
         if (pend_vld_q && state_q != WR) overrun_d = 1'b1;
         pend_vld_d  = 1'b1;
         pend_addr_d = avg_addr;
         pend_data_d = avg_data;
      end

      alarm_d = (alarm_cnt_d == ALARM_MAX);
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state_q        <= IDLE;
         rd_phase_q     <= 1'b0;
         pend_vld_q     <= 1'b0;
         pend_addr_q    <= 11'h000;
         pend_data_q    <= 8'h00;
         rd_addr_q      <= 11'h000;
         rd_data_q      <= 8'h00;
         rd_valid_q     <= 1'b0;
         sample_count_q <= 12'h000;
         min_q          <= 8'hFF;
         max_q          <= 8'h00;
         wrap_q         <= 1'b0;
         overrun_q      <= 1'b0;
         alarm_cnt_q    <= 4'd0;
         alarm_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_phase_q     <= rd_phase_d;
         pend_vld_q     <= pend_vld_d;
         pend_addr_q    <= pend_addr_d;
         pend_data_q    <= pend_data_d;
         rd_addr_q      <= rd_addr_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
         sample_count_q <= sample_count_d;
         min_q          <= min_d;
         max_q          <= max_d;
         wrap_q         <= wrap_d;
         overrun_q      <= overrun_d;
         alarm_cnt_q    <= alarm_cnt_d;
         alarm_q        <= alarm_d;
      end
   end

   // RAM contents survive reset; ram_we and ram_re are mutually exclusive.
   always_ff @(posedge wr_clk) begin
      if (ram_we) mem[pend_addr_q] <= pend_data_q;
      if (ram_re) ram_rd_q <= mem[rd_addr_q];
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign busy         = (state_q != IDLE);
   assign sample_count = sample_count_q;
   assign min_temp     = min_q;
   assign max_temp     = max_q;
   assign wrap_flag    = wrap_q;
   assign overrun      = overrun_q;
   assign alarm        = alarm_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_temp_logger.sv
// Directed bench for temp_logger: writes, reads, overrun, priority, alarm, wrap,
// reset abort and sample-count saturation, checked with immediate assertions.
module tb_temp_logger;

   logic        clk = 1'b0;
   logic        reset;
   logic        avg_valid;
   logic [7:0]  avg_data;
   logic [10:0] avg_addr;
   logic        rd_req;
   logic [10:0] rd_addr;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;
   logic [11:0] sample_count;
   logic [7:0]  min_temp;
   logic [7:0]  max_temp;
   logic        wrap_flag;
   logic        overrun;
   logic        alarm;
   logic [1:0]  dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   temp_logger #(.TEMP_HI(8'd200), .ALARM_CNT(3)) dut (
      .wr_clk(clk), .reset(reset),
      .avg_valid(avg_valid), .avg_data(avg_data), .avg_addr(avg_addr),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .sample_count(sample_count), .min_temp(min_temp), .max_temp(max_temp),
      .wrap_flag(wrap_flag), .overrun(overrun), .alarm(alarm),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe at edge N; write lands at edge N+2, so stats are visible afterwards.
   task automatic write_sample(input logic [10:0] a, input logic [7:0] d);
      avg_valid = 1'b1;
      avg_addr  = a;
      avg_data  = d;
      tick();
      avg_valid = 1'b0;
      tick();
      tick();
   endtask

   // Returns the number of edges from the first sampled rd_req up to rd_valid.
   task automatic do_read(input logic [10:0] a, output logic [7:0] d, output int lat);
      rd_req  = 1'b1;
      rd_addr = a;
      lat     = 0;
      while (lat < 20) begin
         tick();
         lat++;
         if (rd_valid) break;
      end
      rd_req = 1'b0;
      d      = rd_data;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_rd_data"}, 32'(rd_data), 32'h00);
      check({pfx, "_rd_valid"}, 32'(rd_valid), 32'h0);
      check({pfx, "_busy"}, 32'(busy), 32'h0);
      check({pfx, "_count"}, 32'(sample_count), 32'h000);
      check({pfx, "_min"}, 32'(min_temp), 32'hFF);
      check({pfx, "_max"}, 32'(max_temp), 32'h00);
      check({pfx, "_wrap"}, 32'(wrap_flag), 32'h0);
      check({pfx, "_overrun"}, 32'(overrun), 32'h0);
      check({pfx, "_alarm"}, 32'(alarm), 32'h0);
   endtask

   initial begin
      logic [7:0] d;
      int lat;
      int seen_valid;

      reset = 1'b1; avg_valid = 1'b0; avg_data = 8'h00; avg_addr = 11'h000;
      rd_req = 1'b0; rd_addr = 11'h000;
      tick(); tick();
      reset = 1'b0;
      check_reset_values("rst");

      // Two writes then a read back
      write_sample(11'h7FF, 8'h40);
      write_sample(11'h7FE, 8'h50);
      check("w2_count", 32'(sample_count), 32'd2);
      check("w2_min", 32'(min_temp), 32'h40);
      check("w2_max", 32'(max_temp), 32'h50);
      do_read(11'h7FE, d, lat);
      check("rd1_data", 32'(d), 32'h50);
      check("rd1_latency", 32'(lat), 32'd3);
      tick();
      check("rd1_valid_one_cycle", 32'(rd_valid), 32'h0);
      write_sample(11'h7FF, 8'h44);
      check("rd_data_hold", 32'(rd_data), 32'h50);

      // Back-to-back strobes: second replaces first, overrun flagged
      avg_valid = 1'b1; avg_addr = 11'h7FD; avg_data = 8'h10;
      tick();
      avg_data = 8'h20;
      tick();
      avg_valid = 1'b0;
      tick(); tick();
      check("ovr_flag", 32'(overrun), 32'h1);
      check("ovr_count", 32'(sample_count), 32'd4);
      check("ovr_min", 32'(min_temp), 32'h20);
      do_read(11'h7FD, d, lat);
      check("ovr_ram", 32'(d), 32'h20);

      // Read and write arriving together: write is served first
      reset = 1'b1; tick(); reset = 1'b0;
      write_sample(11'h100, 8'h33);
      rd_req = 1'b1; rd_addr = 11'h100;
      avg_valid = 1'b1; avg_addr = 11'h100; avg_data = 8'h77;
      lat = 0;
      tick(); lat++;
      avg_valid = 1'b0;
      while (!rd_valid && lat < 20) begin
         tick(); lat++;
      end
      rd_req = 1'b0;
      check("prio_data", 32'(rd_data), 32'h77);
      check("prio_latency", 32'(lat), 32'd6);
      check("prio_no_overrun", 32'(overrun), 32'h0);
      check("prio_count", 32'(sample_count), 32'd2);

      // Alarm after three consecutive readings at threshold, clears below it
      write_sample(11'h200, 8'hC8);
      write_sample(11'h201, 8'hC8);
      check("alarm_after_2", 32'(alarm), 32'h0);
      write_sample(11'h202, 8'hC8);
      check("alarm_after_3", 32'(alarm), 32'h1);
      write_sample(11'h203, 8'hFF);
      check("alarm_sat", 32'(alarm), 32'h1);
      write_sample(11'h204, 8'hC7);
      check("alarm_clear", 32'(alarm), 32'h0);
      check("alarm_max", 32'(max_temp), 32'hFF);

      // Wrap flag is sticky
      check("wrap_before", 32'(wrap_flag), 32'h0);
      write_sample(11'h000, 8'h05);
      check("wrap_set", 32'(wrap_flag), 32'h1);
      check("wrap_min", 32'(min_temp), 32'h05);
      write_sample(11'h7FF, 8'h06);
      check("wrap_sticky", 32'(wrap_flag), 32'h1);

      // Reset while a read is in flight aborts it
      rd_req = 1'b1; rd_addr = 11'h100;
      tick();
      check("abort_busy", 32'(busy), 32'h1);
      reset = 1'b1; rd_req = 1'b0;
      tick();
      reset = 1'b0;
      check_reset_values("abort");
      seen_valid = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rd_valid) seen_valid++;
      end
      check("abort_no_valid", 32'(seen_valid), 32'd0);
      do_read(11'h100, d, lat);
      check("ram_kept", 32'(d), 32'h77);

      // Sample count saturates at 0xFFF
      for (int i = 0; i < 4095; i++) write_sample(11'(i), 8'h80);
      check("count_full", 32'(sample_count), 32'hFFF);
      write_sample(11'h123, 8'h81);
      check("count_sat", 32'(sample_count), 32'hFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/temp_logger.md
TEMP_LOGGER -- requirements
Module: temp_logger

Interface
REQ-001 SHALL have parameter TEMP_HI, default 8'd200, over-temperature threshold (inclusive).
REQ-002 SHALL have parameter ALARM_CNT, default 3, consecutive over-threshold samples needed to raise alarm (range 1-15).
REQ-003 SHALL have port wr_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port avg_valid  input  1  one-cycle strobe: new averaged reading present.
REQ-006 SHALL have port avg_data  input  8  averaged temperature reading, unsigned.
REQ-007 SHALL have port avg_addr  input  11  target RAM address for avg_data (0x7FF down to 0x000).
REQ-008 SHALL have port rd_req  input  1  read request, level, held until rd_valid.
REQ-009 SHALL have port rd_addr  input  11  read address, stable while rd_req high.
REQ-010 SHALL have port rd_data  output  8  registered read data.
REQ-011 SHALL have port rd_valid  output  1  one-cycle strobe: rd_data valid.
REQ-012 SHALL have port busy  output  1  high when FSM not in IDLE.
REQ-013 SHALL have port sample_count  output  12  completed writes, saturating.
REQ-014 SHALL have port min_temp / max_temp  output  8 each  extremes of written readings.
REQ-015 SHALL have port wrap_flag  output  1  sticky: address 0x000 has been written.
REQ-016 SHALL have port overrun  output  1  sticky: a pending reading was overwritten before storage.
REQ-017 SHALL have port alarm  output  1  over-temperature alarm.

Function
REQ-018 SHALL contain a 2048x8 single-port RAM; at most one access (read or write) per cycle.
REQ-019 SHALL latch {avg_addr, avg_data} into a pending register and set pend_vld on any edge with avg_valid=1.
REQ-020 SHALL set overrun if avg_valid=1 while pend_vld=1 and FSM not in WR; new reading replaces pending one.
REQ-021 SHALL implement FSM states IDLE, WR, RD; reset state IDLE.
REQ-022 IDLE: pend_vld=1 -> WR (write priority); else rd_req=1 -> RD, capturing rd_addr; else stay.
REQ-023 WR: write pending data to pending address, clear pend_vld (stays set if avg_valid=1 same cycle, no overrun), update stats, -> IDLE.
REQ-024 RD: rd_data <= RAM[captured addr], rd_valid <= 1 for exactly one cycle, -> IDLE.
REQ-025 Latency: avg_valid at edge N -> RAM write and stats update at edge N+2 when FSM idle.
REQ-026 Latency: rd_req seen at edge N with no pending write -> rd_valid high after edge N+2, for one cycle.
REQ-027 rd_req held past rd_valid SHALL start a new read; a pending write arriving meanwhile SHALL be served first, delaying rd_valid.
REQ-028 sample_count SHALL increment per WR and hold at 12'hFFF.
REQ-029 min_temp/max_temp SHALL update on each WR by unsigned compare; equal values leave them unchanged.
REQ-030 wrap_flag SHALL set on WR to address 0x000 and stay set until reset; logging continues.
REQ-031 Alarm counter (4-bit) SHALL increment, saturating at ALARM_CNT, on WR with data >= TEMP_HI and clear to 0 on WR with data < TEMP_HI.
REQ-032 alarm SHALL equal (alarm counter == ALARM_CNT), registered.
REQ-033 rd_data SHALL hold last read value between reads.

Reset
REQ-034 With reset=1 at an edge: FSM IDLE, pend_vld=0, rd_data=0, rd_valid=0, sample_count=0, min_temp=8'hFF, max_temp=8'h00, wrap_flag=0, overrun=0, alarm=0, alarm counter=0.
REQ-035 Reset mid-operation SHALL abort any pending write or read; no rd_valid issued for aborted read.
REQ-036 RAM contents SHALL NOT be cleared by reset; reads of unwritten addresses return undefined data.

Verification
REQ-037 Write 0x40@0x7FF, 0x50@0x7FE, then read 0x7FE -> rd_data=0x50, rd_valid one cycle at N+2; sample_count=2, min=0x40, max=0x50.
REQ-038 avg_valid on two consecutive cycles (0x10, 0x20 @0x7FD) -> overrun=1, RAM[0x7FD]=0x20, sample_count=1.
REQ-039 rd_req held while avg_valid arrives same cycle -> write completes first, rd_valid one cycle later returns new data at that address.
REQ-040 Three writes of 0xC8 (TEMP_HI=200, ALARM_CNT=3) -> alarm=1 after third; next write 0xC7 -> alarm=0.
REQ-041 Write to 0x000 -> wrap_flag=1; following write to 0x7FF -> wrap_flag stays 1.
REQ-042 Assert reset during RD state -> no rd_valid, all outputs at REQ-034 values next cycle.
